w_mem_bank: RTL and testbench

- Run-time loadable successor to the fixed two-set weight ROM.
- Holds N_SETS complete weight sets for the generator (wg2, wg3) and discriminator (wd2, wd3) layers.
- Each set is loaded word-serially over a valid/ready stream into a shadow buffer, then committed atomically into a target bank slot.
- Each layer independently selects which set drives its registered output bus; the outputs feed the existing layer datapaths unchanged.

---
 rtl/w_mem_bank_pkg.sv | 25 ++
 rtl/w_load_ctrl.sv | 85 ++++++++
 rtl/w_mem_bank.sv | 131 +++++++++++++
 tb/tb_w_mem_bank.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_mem_bank_pkg.sv
// Shared types and sizing helpers for the run-time loadable weight bank.
// Stream layout: wg2 words, then wg3, wd2 and wd3, each packed neuron-major.
package w_mem_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } ld_state_t;

   function automatic int layer_words(input int fan_in, input int n_neurons);
      return fan_in * n_neurons;
   endfunction

   function automatic int total_words(input int n_input, input int n_g_l2, input int n_g_l3,
                                      input int n_d_l2, input int n_d_l3);
      return layer_words(n_input, n_g_l2) + layer_words(n_g_l2, n_g_l3) +
             layer_words(n_g_l3, n_d_l2) + layer_words(n_d_l2, n_d_l3);
   endfunction

   function automatic int cnt_width(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/w_load_ctrl.sv
// Load sequencer: IDLE -> LOAD (word-serial fill of the shadow buffer) -> COMMIT.
// Drives the shadow write port and a one-cycle commit strobe for the bank.
module w_load_ctrl
   import w_mem_bank_pkg::*;
#(
   parameter int N_SETS = 4,
   parameter int SEL_W  = 2,
   parameter int TOTAL  = 63,
   parameter int CNT_W  = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_start,
   input  logic [SEL_W-1:0] ld_set,
   input  logic             ld_abort,
   input  logic             ld_valid,
   output logic             ld_ready,
   output logic             ld_busy,
   output logic             ld_done,
   output logic             ld_err,
   output logic             shadow_we,
   output logic [CNT_W-1:0] shadow_idx,
   output logic             commit,
   output logic [SEL_W-1:0] commit_slot
);

   ld_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] slot;
   logic             set_ok;
   logic             last_word;

   assign set_ok    = int'(ld_set) < N_SETS;
   assign last_word = (cnt == CNT_W'(TOTAL - 1));

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the default assignment first keeps this combinational block latch-free.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (ld_start && set_ok) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (ld_abort)                   state_nxt = ST_IDLE;
            else if (ld_valid && last_word) state_nxt = ST_COMMIT;
         end
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Abort suppresses the shadow write so an abandoned final word is never counted.
   always_comb begin
      ld_ready  = (state == ST_LOAD);
      ld_busy   = (state == ST_LOAD) || (state == ST_COMMIT);
      shadow_we = ld_ready && ld_valid && !ld_abort;
      commit    = (state == ST_COMMIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         slot    <= '0;
         ld_done <= 1'b0;
         ld_err  <= 1'b0;
      end else begin
         if (state == ST_IDLE && ld_start && set_ok) begin
            slot <= ld_set;
            cnt  <= '0;
         end else if (shadow_we) begin
            cnt <= cnt + CNT_W'(1);
         end
         ld_done <= commit;
         ld_err  <= (state == ST_IDLE) && ld_start && !set_ok;
      end
   end

   assign shadow_idx  = cnt;
   assign commit_slot = slot;

endmodule

// File: rtl/w_mem_bank.sv
// N_SETS weight sets for the generator/discriminator layers, loaded via a shadow
// buffer and committed atomically; each layer bus selects its set independently.
module w_mem_bank
   import w_mem_bank_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int N_INPUT = 2,
   parameter int N_G_L2 = 3,
   parameter int N_G_L3 = 9,
   parameter int N_D_L2 = 3,
   parameter int N_D_L3 = 1,
   parameter int N_SETS = 4,
   parameter int SEL_W  = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              ld_start,
   input  logic [SEL_W-1:0]                  ld_set,
   input  logic                              ld_abort,
   input  logic                              ld_valid,
   input  logic [WIDTH-1:0]                  ld_data,
   output logic                              ld_ready,
   output logic                              ld_busy,
   output logic                              ld_done,
   output logic                              ld_err,
   output logic [N_SETS-1:0]                 set_valid,
   input  logic [SEL_W-1:0]                  sel_g2,
   input  logic [SEL_W-1:0]                  sel_g3,
   input  logic [SEL_W-1:0]                  sel_d2,
   input  logic [SEL_W-1:0]                  sel_d3,
   output logic [N_INPUT*N_G_L2*WIDTH-1:0]   wg2,
   output logic [N_G_L2*N_G_L3*WIDTH-1:0]    wg3,
   output logic [N_G_L3*N_D_L2*WIDTH-1:0]    wd2,
   output logic [N_D_L2*N_D_L3*WIDTH-1:0]    wd3
);

   localparam int G2_WORDS = layer_words(N_INPUT, N_G_L2);
   localparam int G3_WORDS = layer_words(N_G_L2, N_G_L3);
   localparam int D2_WORDS = layer_words(N_G_L3, N_D_L2);
   localparam int D3_WORDS = layer_words(N_D_L2, N_D_L3);
   localparam int G2_OFF   = 0;
   localparam int G3_OFF   = G2_OFF + G2_WORDS;
   localparam int D2_OFF   = G3_OFF + G3_WORDS;
   localparam int D3_OFF   = D2_OFF + D2_WORDS;
   localparam int TOTAL    = total_words(N_INPUT, N_G_L2, N_G_L3, N_D_L2, N_D_L3);
   localparam int CNT_W    = cnt_width(TOTAL);

   logic [TOTAL*WIDTH-1:0] shadow;
   logic [TOTAL*WIDTH-1:0] bank [N_SETS];
   logic                   shadow_we;
   logic [CNT_W-1:0]       shadow_idx;
   logic                   commit;
   logic [SEL_W-1:0]       commit_slot;

   logic [G2_WORDS*WIDTH-1:0] g2_nxt;
   logic [G3_WORDS*WIDTH-1:0] g3_nxt;
   logic [D2_WORDS*WIDTH-1:0] d2_nxt;
   logic [D3_WORDS*WIDTH-1:0] d3_nxt;

   w_load_ctrl #(
      .N_SETS (N_SETS),
      .SEL_W  (SEL_W),
      .TOTAL  (TOTAL),
      .CNT_W  (CNT_W)
   ) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_start    (ld_start),
      .ld_set      (ld_set),
      .ld_abort    (ld_abort),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_busy     (ld_busy),
      .ld_done     (ld_done),
      .ld_err      (ld_err),
      .shadow_we   (shadow_we),
      .shadow_idx  (shadow_idx),
      .commit      (commit),
      .commit_slot (commit_slot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow <= '0;
      else if (shadow_we) shadow[int'(shadow_idx)*WIDTH +: WIDTH] <= ld_data;
   end

   // NOTE: the banks are held in resettable flops, not RAM, because any layer may
   // select a slot before it is ever loaded and must then read zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_SETS; k++) bank[k] <= '0;
         set_valid <= '0;
      end else if (commit) begin
         for (int k = 0; k < N_SETS; k++) begin
            if (commit_slot == SEL_W'(k)) begin
               bank[k]      <= shadow;
               set_valid[k] <= 1'b1;
            end
         end
      end
   end

   // Out-of-range selects match no slot and leave the bus at zero.
   always_comb begin
      g2_nxt = '0;
      g3_nxt = '0;
      d2_nxt = '0;
      d3_nxt = '0;
      for (int k = 0; k < N_SETS; k++) begin
         if (sel_g2 == SEL_W'(k)) g2_nxt = bank[k][G2_OFF*WIDTH +: G2_WORDS*WIDTH];
         if (sel_g3 == SEL_W'(k)) g3_nxt = bank[k][G3_OFF*WIDTH +: G3_WORDS*WIDTH];
         if (sel_d2 == SEL_W'(k)) d2_nxt = bank[k][D2_OFF*WIDTH +: D2_WORDS*WIDTH];
         if (sel_d3 == SEL_W'(k)) d3_nxt = bank[k][D3_OFF*WIDTH +: D3_WORDS*WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wg2 <= '0;
         wg3 <= '0;
         wd2 <= '0;
         wd3 <= '0;
      end else begin
         wg2 <= g2_nxt;
         wg3 <= g3_nxt;
         wd2 <= d2_nxt;
         wd3 <= d3_nxt;
      end
   end

endmodule

// File: tb/tb_w_mem_bank.sv
// Scoreboard bench for w_mem_bank: expected done/err pulses are queued by the
// stimulus and popped by a negedge monitor; bus contents come from a bench-side model.
module tb_w_mem_bank;

   localparam int WIDTH   = 32;
   localparam int N_INPUT = 2;
   localparam int N_G_L2  = 3;
   localparam int N_G_L3  = 9;
   localparam int N_D_L2  = 3;
   localparam int N_D_L3  = 1;
   localparam int N_SETS  = 4;
   localparam int SEL_W   = 3;
   localparam int G3_OFF  = 6;
   localparam int D2_OFF  = 33;
   localparam int D3_OFF  = 60;
   localparam int TOTAL   = 63;

   logic                 clk;
   logic                 rst_n;
   logic                 ld_start;
   logic [SEL_W-1:0]     ld_set;
   logic                 ld_abort;
   logic                 ld_valid;
   logic [WIDTH-1:0]     ld_data;
   logic                 ld_ready;
   logic                 ld_busy;
   logic                 ld_done;
   logic                 ld_err;
   logic [N_SETS-1:0]    set_valid;
   logic [SEL_W-1:0]     sel_g2, sel_g3, sel_d2, sel_d3;
   logic [6*WIDTH-1:0]   wg2;
   logic [27*WIDTH-1:0]  wg3;
   logic [27*WIDTH-1:0]  wd2;
   logic [3*WIDTH-1:0]   wd3;

   w_mem_bank #(
      .WIDTH   (WIDTH),
      .N_INPUT (N_INPUT),
      .N_G_L2  (N_G_L2),
      .N_G_L3  (N_G_L3),
      .N_D_L2  (N_D_L2),
      .N_D_L3  (N_D_L3),
      .N_SETS  (N_SETS),
      .SEL_W   (SEL_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_start  (ld_start),
      .ld_set    (ld_set),
      .ld_abort  (ld_abort),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .ld_busy   (ld_busy),
      .ld_done   (ld_done),
      .ld_err    (ld_err),
      .set_valid (set_valid),
      .sel_g2    (sel_g2),
      .sel_g3    (sel_g3),
      .sel_d2    (sel_d2),
      .sel_d3    (sel_d3),
      .wg2       (wg2),
      .wg3       (wg3),
      .wd2       (wd2),
      .wd3       (wd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum logic [1:0] {EV_ERR = 2'b01, EV_DONE = 2'b10} ev_kind_t;
   typedef struct {
      ev_kind_t          kind;
      logic [N_SETS-1:0] sv;
   } ev_t;

   ev_t               exp_q[$];
   int                checks = 0;
   int                errors = 0;
   int                ready_cycles = 0;
   logic [N_SETS-1:0] exp_sv = '0;
   logic [WIDTH-1:0]  model [N_SETS][TOTAL];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] bus_word(input int g);
      if (g < G3_OFF)      return wg2[g*WIDTH +: WIDTH];
      else if (g < D2_OFF) return wg3[(g-G3_OFF)*WIDTH +: WIDTH];
      else if (g < D3_OFF) return wd2[(g-D2_OFF)*WIDTH +: WIDTH];
      else                 return wd3[(g-D3_OFF)*WIDTH +: WIDTH];
   endfunction

   // Monitor: every done/err pulse must match the head of the expected queue.
   always @(negedge clk) begin : monitor
      ev_t e;
      if (rst_n) begin
         if (ld_ready) ready_cycles++;
         if (ld_done || ld_err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {62'b0, ld_done, ld_err}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("pulse_kind", {62'b0, ld_done, ld_err}, {62'b0, e.kind});
               check("set_valid_at_pulse", {60'b0, set_valid}, {60'b0, e.sv});
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input int s);
      sel_g2 = SEL_W'(s);
      sel_g3 = SEL_W'(s);
      sel_d2 = SEL_W'(s);
      sel_d3 = SEL_W'(s);
      tick();
      tick();
   endtask

   task automatic check_bus(input string tag, input int s);
      logic [WIDTH-1:0] exp;
      @(negedge clk);
      for (int g = 0; g < TOTAL; g++) begin
         exp = (s < N_SETS) ? model[s][g] : '0;
         check($sformatf("%s_w%0d", tag, g), {32'b0, bus_word(g)}, {32'b0, exp});
      end
   endtask

   task automatic load(input int slot, input logic [WIDTH-1:0] base, input bit throttle,
                       input bit abort_last, input bit stray_start, input bit watch_d2);
      ev_t              e;
      int               guard;
      logic [WIDTH-1:0] d2_old;
      d2_old = model[0][D2_OFF];
      ready_cycles = 0;
      if (!abort_last) begin
         exp_sv = exp_sv | N_SETS'(1 << slot);
         e.kind = EV_DONE;
         e.sv   = exp_sv;
         exp_q.push_back(e);
      end
      ld_set   = SEL_W'(slot);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int k = 0; k < TOTAL; k++) begin
         if (throttle && k > 0) begin
            ld_valid = 1'b0;
            tick();
         end
         ld_valid = 1'b1;
         ld_data  = base + WIDTH'(k);
         ld_abort = abort_last && (k == TOTAL - 1);
         if (stray_start && k == 10) begin
            ld_start = 1'b1;
            ld_set   = SEL_W'(1);
         end
         guard = 0;
         @(negedge clk);
         while (!ld_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         check($sformatf("ld_ready_word%0d", k), {63'b0, ld_ready}, 64'd1);
         tick();
         ld_start = 1'b0;
         ld_abort = 1'b0;
      end
      ld_valid = 1'b0;
      if (!abort_last)
         for (int k = 0; k < TOTAL; k++) model[slot][k] = base + WIDTH'(k);
      if (watch_d2) begin
         guard = 0;
         @(negedge clk);
         while (!ld_done && guard < 5) begin
            @(negedge clk);
            guard++;
         end
         check("done_for_watch", {63'b0, ld_done}, 64'd1);
         check("wd2_old_at_done", {32'b0, wd2[0 +: WIDTH]}, {32'b0, d2_old});
         @(negedge clk);
         check("wd2_new_next_cycle", {32'b0, wd2[0 +: WIDTH]}, {32'b0, model[0][D2_OFF]});
      end
      repeat (4) tick();
   endtask

   initial begin : stimulus
      ev_t e;
      for (int s = 0; s < N_SETS; s++)
         for (int g = 0; g < TOTAL; g++) model[s][g] = '0;
      rst_n    = 1'b0;
      ld_start = 1'b0;
      ld_set   = '0;
      ld_abort = 1'b0;
      ld_valid = 1'b0;
      ld_data  = '0;
      sel_g2   = '0;
      sel_g3   = '0;
      sel_d2   = '0;
      sel_d3   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_set_valid", {60'b0, set_valid}, 64'd0);
      check("rst_ld_ready", {63'b0, ld_ready}, 64'd0);
      check("rst_ld_busy", {63'b0, ld_busy}, 64'd0);
      check("rst_ld_done_err", {62'b0, ld_done, ld_err}, 64'd0);
      check_bus("rst_bus", 0);
      #2 rst_n = 1'b1;
      set_sel(0);
      check_bus("idle_sel0", 0);

      // Plain load of slot 2
      load(2, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ready_cycles_63", 64'(ready_cycles), 64'd63);
      check("sv_after_slot2", {60'b0, set_valid}, 64'b0100);
      set_sel(2);
      @(negedge clk);
      check("wg3_word0", {32'b0, wg3[0 +: WIDTH]}, 64'h0001_0006);
      check("wd3_word2", {32'b0, wd3[2*WIDTH +: WIDTH]}, 64'h0001_003E);
      check_bus("slot2", 2);

      // Throttled load of slot 3 with a stray ld_start mid-load
      load(3, 32'h0001_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      check("sv_after_slot3", {60'b0, set_valid}, 64'b1100);
      check("busy_after_slot3", {63'b0, ld_busy}, 64'd0);
      set_sel(3);
      check_bus("slot3", 3);

      // Abort on the final word into slot 1
      load(1, 32'h0003_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      check("sv_after_abort", {60'b0, set_valid}, 64'b1100);
      check("busy_after_abort", {63'b0, ld_busy}, 64'd0);
      set_sel(1);
      check_bus("slot1_abort", 1);

      // Illegal ld_set from IDLE
      for (int t = 0; t < 2; t++) begin
         e.kind = EV_ERR;
         e.sv   = exp_sv;
         exp_q.push_back(e);
         ld_set   = (t == 0) ? SEL_W'(5) : SEL_W'(4);
         ld_start = 1'b1;
         tick();
         ld_start = 1'b0;
         @(negedge clk);
         check($sformatf("err%0d_busy", t), {63'b0, ld_busy}, 64'd0);
         check($sformatf("err%0d_pulse", t), {63'b0, ld_err}, 64'd1);
         repeat (2) tick();
      end

      // Out-of-range select drives zero even with populated slots
      set_sel(6);
      check_bus("sel6", 6);

      // Commit visibility on wd2 while selecting slot 0
      set_sel(0);
      load(0, 32'h0004_0000, 1'b0, 1'b0, 1'b0, 1'b1);
      check("sv_after_slot0", {60'b0, set_valid}, 64'b1101);
      check_bus("slot0", 0);

      // Asynchronous reset during a load
      set_sel(2);
      ld_set   = SEL_W'(2);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         ld_data = 32'h0005_0000 + WIDTH'(k);
         tick();
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_wg3", {32'b0, wg3[0 +: WIDTH]}, 64'd0);
      check("arst_wd3", {32'b0, wd3[2*WIDTH +: WIDTH]}, 64'd0);
      check("arst_set_valid", {60'b0, set_valid}, 64'd0);
      check("arst_busy_ready", {62'b0, ld_busy, ld_ready}, 64'd0);
      ld_valid = 1'b0;
      for (int s = 0; s < N_SETS; s++)
         for (int g = 0; g < TOTAL; g++) model[s][g] = '0;
      exp_sv = '0;
      tick();
      #2 rst_n = 1'b1;
      set_sel(2);
      check_bus("after_arst", 2);

      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
